// File: rtl/result_writer_pkg.sv
// Shared types and frame constants for the overlay result writer.
package result_writer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_TOP,
        S_BOTTOM,
        S_LEFT,
        S_RIGHT,
        S_DONE,
        S_CDONE
    } rw_state_t;

    localparam int IMG_W_DEF = 160;
    localparam int IMG_H_DEF = 120;
    localparam int PIX_CNT   = IMG_W_DEF * IMG_H_DEF;

endpackage

// File: rtl/ovl_addr_gen.sv
// Registers the linear overlay address and the clipped write enable for the
// pixel the iterator is about to visit, so both leave in the same cycle.
module ovl_addr_gen #(
    parameter int CW             = 9,
    parameter int WIDTH_OVL_ADDR = 16,
    parameter int IMG_W          = 160,
    parameter int IMG_H          = 120
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr,
    input  logic [CW-1:0]             x,
    input  logic [CW-1:0]             y,
    output logic                      we,
    output logic [WIDTH_OVL_ADDR-1:0] addr
);

    localparam int PW = WIDTH_OVL_ADDR + CW;
    localparam logic [CW-1:0] W_C = CW'(IMG_W);
    localparam logic [CW-1:0] H_C = CW'(IMG_H);

    logic          clip;
    logic [PW-1:0] lin;

    assign clip = (x >= W_C) || (y >= H_C);
    // Constant multiply; synthesis reduces it to shifts and adds.
    assign lin  = PW'(y) * PW'(IMG_W) + PW'(x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we   <= 1'b0;
            addr <= '0;
        end else begin
            we <= wr && !clip;
            if (wr) addr <= lin[WIDTH_OVL_ADDR-1:0];
        end
    end

endmodule

// File: rtl/result_writer.sv
// Draws a detection window outline into a 1-bit overlay BRAM, one pixel per
// cycle, and clears the overlay on request.
module result_writer
    import result_writer_pkg::*;
#(
    parameter int WIDTH_POSI     = 8,
    parameter int WIDTH_OVL_ADDR = 16,
    parameter int IMG_W          = IMG_W_DEF,
    parameter int IMG_H          = IMG_H_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      write_result_start,
    input  logic [WIDTH_POSI-1:0]     xpos,
    input  logic [WIDTH_POSI-1:0]     ypos,
    input  logic [WIDTH_POSI-1:0]     length,
    output logic                      write_result_done,
    input  logic                      clear_start,
    output logic                      clear_done,
    output logic                      busy,
    output logic                      we_ovl,
    output logic [WIDTH_OVL_ADDR-1:0] addr_ovl,
    output logic                      dout_ovl
);

    localparam int CW = WIDTH_POSI + 1;
    localparam logic [CW-1:0] XLAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] YLAST = CW'(IMG_H - 1);

    rw_state_t state, next;

    logic [WIDTH_POSI-1:0] x0, y0, len;
    logic [CW-1:0]         cx, cy, nx, ny;
    logic [CW-1:0]         x0e, xe, ye, ym, y1;
    logic                  ld, wr_next, draw_next;

    // Window corners at one extra bit so x0+L-1 never wraps.
    assign x0e = {1'b0, x0};
    assign xe  = {1'b0, x0} + {1'b0, len} - CW'(1);
    assign ye  = {1'b0, y0} + {1'b0, len} - CW'(1);
    assign ym  = ye - CW'(1);
    assign y1  = {1'b0, y0} + CW'(1);

    assign draw_next = (next == S_TOP) || (next == S_BOTTOM) ||
                       (next == S_LEFT) || (next == S_RIGHT);
    assign wr_next   = draw_next || (next == S_CLEAR);

    always_comb begin
        next = state;
        nx   = cx;
        ny   = cy;
        ld   = 1'b0;
        case (state)
            S_IDLE: begin
                if (clear_start) begin
                    next = S_CLEAR;
                    nx   = '0;
                    ny   = '0;
                end else if (write_result_start) begin
                    ld = 1'b1;
                    nx = {1'b0, xpos};
                    ny = {1'b0, ypos};
                    next = (length == '0) ? S_DONE : S_TOP;
                end
            end
            S_CLEAR: begin
                if (cx == XLAST) begin
                    nx = '0;
                    ny = cy + CW'(1);
                    if (cy == YLAST) next = S_CDONE;
                end else begin
                    nx = cx + CW'(1);
                end
            end
            S_TOP: begin
                if (cx == xe) begin
                    if (len == WIDTH_POSI'(1)) begin
                        next = S_DONE;
                    end else begin
                        next = S_BOTTOM;
                        nx   = x0e;
                        ny   = ye;
                    end
                end else begin
                    nx = cx + CW'(1);
                end
            end
            S_BOTTOM: begin
                if (cx == xe) begin
                    if (len <= WIDTH_POSI'(2)) begin
                        next = S_DONE;
                    end else begin
                        next = S_LEFT;
                        nx   = x0e;
                        ny   = y1;
                    end
                end else begin
                    nx = cx + CW'(1);
                end
            end
            S_LEFT: begin
                if (cy == ym) begin
                    next = S_RIGHT;
                    nx   = xe;
                    ny   = y1;
                end else begin
                    ny = cy + CW'(1);
                end
            end
            S_RIGHT: begin
                if (cy == ym) next = S_DONE;
                else          ny = cy + CW'(1);
            end
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            write_result_done <= 1'b0;
            clear_done        <= 1'b0;
            busy              <= 1'b0;
            dout_ovl          <= 1'b0;
        end else begin
            state             <= next;
            write_result_done <= (next == S_DONE);
            clear_done        <= (next == S_CDONE);
            busy              <= (next != S_IDLE);
            dout_ovl          <= draw_next;
        end
    end

    // Datapath registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        cx <= nx;
        cy <= ny;
        if (ld) begin
            x0  <= xpos;
            y0  <= ypos;
            len <= length;
        end
    end

    ovl_addr_gen #(
        .CW             (CW),
        .WIDTH_OVL_ADDR (WIDTH_OVL_ADDR),
        .IMG_W          (IMG_W),
        .IMG_H          (IMG_H)
    ) u_addr (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr_next),
        .x     (nx),
        .y     (ny),
        .we    (we_ovl),
        .addr  (addr_ovl)
    );

endmodule

// File: doc/result_writer.md
# result_writer

Responder end of the face detection engine's result-writer handshake. On each write request it latches the detected window (`xpos`, `ypos`, `length`) and draws its square outline, one pixel per cycle, into a 1-bit overlay BRAM. The display path later reads that BRAM. Once the outline is written it returns a one-cycle done pulse. It also clears the overlay on request, once per frame, before detections are drawn.

## Interface
- `WIDTH_POSI`, 8: width of position/length fields
- `WIDTH_OVL_ADDR`, 16: overlay BRAM address width
- `IMG_W`, 160: frame width in pixels
- `IMG_H`, 120: frame height in pixels
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `write_result_start` in 1: draw request, level, sampled only in IDLE
- `xpos` in WIDTH_POSI: window left column, sampled with start
- `ypos` in WIDTH_POSI: window top row, sampled with start
- `length` in WIDTH_POSI: window side in pixels, sampled with start
- `write_result_done` out 1: one-cycle pulse, draw finished
- `clear_start` in 1: overlay clear request, level, sampled only in IDLE
- `clear_done` out 1: one-cycle pulse, clear finished
- `busy` out 1: high in any state other than IDLE
- `we_ovl` out 1: overlay write enable
- `addr_ovl` out WIDTH_OVL_ADDR: overlay write address, y*IMG_W + x
- `dout_ovl` out 1: write data; 1 when drawing, 0 when clearing

## Operation
- States: IDLE, CLEAR, TOP, BOTTOM, LEFT, RIGHT, DONE, CDONE.
- IDLE:
  - `clear_start` goes to CLEAR, address counter = 0.
  - Otherwise `write_result_start` latches x0/y0/L and goes to TOP, or straight to DONE when L==0.
  - Clear has priority when both requests are high.
- CLEAR: one write per cycle, `dout_ovl`=0, addresses 0 .. IMG_W*IMG_H-1 ascending. After the last address, go to CDONE.
- TOP: x = x0 .. x0+L-1, y = y0.
- BOTTOM: x = x0 .. x0+L-1, y = y0+L-1. Skipped when L==1.
- LEFT: x = x0, y = y0+1 .. y0+L-2. Skipped when L<=2.
- RIGHT: x = x0+L-1, y = y0+1 .. y0+L-2. Skipped when L<=2.
- Segment order is TOP→BOTTOM→LEFT→RIGHT→DONE; a skipped segment passes to the next in the same edge.
- Draw writes use `dout_ovl`=1. Write count is 1 for L==1 and 4L-4 for L>=2.
- Arithmetic: coordinates are formed at WIDTH_POSI+1 bits, so x0+L-1 never wraps.
- Clipping: a pixel with x>=IMG_W or y>=IMG_H still takes its cycle and the iterator advances, but `we_ovl` stays 0 for that cycle.
- DONE: `write_result_done`=1 for one cycle, then IDLE. CDONE: `clear_done`=1 for one cycle, then IDLE.
- Requests arriving while busy are ignored, not queued.
- If `write_result_start` is still high in the IDLE cycle after DONE, a new draw starts. The initiator must drop start on seeing done.

## Timing
- Reset values: state IDLE; `write_result_done`, `clear_done`, `busy`, `we_ovl`, `dout_ovl` = 0; `addr_ovl` = 0.
- Reset asserted mid-operation aborts immediately: `we_ovl` goes 0 asynchronously and no done pulse is issued.
- All outputs are registered.
- Draw latency: start is sampled at edge k; the first `we_ovl` is visible in cycle k+1, with one write slot per cycle.
- For L>=2 the done pulse is in cycle k+4L-3. For L==1 it is in k+2. For L==0 it is in k+1.
- Clear latency: `clear_done` is in cycle k+IMG_W*IMG_H+1.
- `busy` rises in cycle k+1 and falls in the cycle after the done pulse.

## Structure
- Package `result_writer_pkg` holds:
  - the state enum (`rw_state_t`)
  - default IMG_W/IMG_H constants
  - the IMG_W*IMG_H pixel-count constant
- Sub-module `ovl_addr_gen`:
  - registered y*IMG_W+x, which may be constant-multiply shift/add
  - clip flag (x>=IMG_W or y>=IMG_H)
  - both aligned with the segment iterator, so `we_ovl` and `addr_ovl` leave in the same cycle.

## Test plan
- Draw x=10, y=20, L=4 → 12 writes with `dout_ovl`=1. Addresses: 3210..3213 (top), 3690..3693 (bottom), 3370, 3530 (left), 3373, 3533 (right). `write_result_done` pulses in cycle k+13.
- L=1 at (0,0) → single write to address 0, done at k+2. L=0 → no writes, done at k+1.
- Clipping, x=155, y=118, L=8 → only in-frame pixels written (x 155..159 on row 118; column 155 rows 119), each in its own cycle slot. Done at k+29.
- `clear_start` and `write_result_start` both high in IDLE → clear runs first: 19200 writes of 0, addresses 0..19199, `clear_done` at k+19201. The draw then starts from the still-high start.
- Reset pulsed mid-TOP at L=20 → `we_ovl` drops immediately, no done pulse. After reset, a new start draws the full outline.
- Start held high after done, and start pulsed while busy → the held start re-triggers a draw, while the pulse during busy produces no extra writes.
